// File: rtl/blink_arbiter_pkg.sv
// Types and default sizes shared by the blink arbiter and its timer.
package blink_arbiter_pkg;
`include "blink_defs.vh"

  typedef enum logic [1:0] {
    ST_IDLE = `BLINK_ST_IDLE,
    ST_RUN  = `BLINK_ST_RUN,
    ST_GAP  = `BLINK_ST_GAP
  } state_t;

  localparam int DEF_NREQ = `BLINK_NREQ;
  localparam int DEF_CW   = `BLINK_CW;
  localparam int DEF_NW   = `BLINK_NW;
  localparam int DEF_GAP  = `BLINK_GAP;

endpackage

// File: rtl/blink_defs.vh
// Shared FSM encodings and default parameter values for the blink arbiter.
`ifndef BLINK_DEFS_VH
`define BLINK_DEFS_VH

`define BLINK_ST_IDLE 2'd0
`define BLINK_ST_RUN  2'd1
`define BLINK_ST_GAP  2'd2

`define BLINK_NREQ 4
`define BLINK_CW   20
`define BLINK_NW   8
`define BLINK_GAP  4

`endif

// File: rtl/blink_timer.sv
// Half-period countdown: one-cycle tick at expiry, self-reloading.
// A period of 0 is treated as 1 so the tick never stalls.
module blink_timer
  import blink_arbiter_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [CW-1:0] period,
  output logic          tick
);

  logic [CW-1:0] per_m1;   // latched period minus one
  logic [CW-1:0] cnt;
  logic [CW-1:0] load_m1;

  assign load_m1 = (period == '0) ? '0 : period - 1'b1;
  assign tick    = (cnt == '0);

  // Count down; reload the latched period on each expiry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_m1 <= '0;
      cnt    <= '0;
    end else if (load) begin
      per_m1 <= load_m1;
      cnt    <= load_m1;
    end else if (tick) begin
      cnt    <= per_m1;
    end else begin
      cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/blink_arbiter.sv
// Round-robin arbiter sharing one LED between NREQ blink requesters.
// IDLE arbitrates, RUN blinks for the owner, GAP enforces idle spacing.
module blink_arbiter
  import blink_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int CW   = DEF_CW,
  parameter int NW   = DEF_NW,
  parameter int GAP  = DEF_GAP
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   half_period,
  input  logic [NREQ*NW-1:0]   num_toggles,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic                 led
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, own_q, win_idx;
  logic [NW-1:0]   tog_cnt;
  logic [GW-1:0]   gap_cnt;
  logic [CW-1:0]   win_hp;
  logic [NW-1:0]   win_nt;
  logic            any_req, load, tick;
  logic            abandon, finish, toggle;

  assign any_req = |req;
  assign load    = (state_q == ST_IDLE) && any_req;
  assign busy    = (state_q != ST_IDLE);
  assign win_hp  = half_period[int'(win_idx)*CW +: CW];
  assign win_nt  = num_toggles[int'(win_idx)*NW +: NW];

  // Round-robin search from the pointer; lowest offset wins, so scan down.
  always_comb begin
    win_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % NREQ])
        win_idx = PW'((int'(ptr_q) + i) % NREQ);
    end
  end

  blink_timer #(.CW(CW)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .period (win_hp),
    .tick   (tick)
  );

  // Run events: abandon beats completion; count 0 completes on the first RUN edge.
  always_comb begin
    abandon = (state_q == ST_RUN) && !req[own_q];
    finish  = (state_q == ST_RUN) && !abandon &&
              ((tog_cnt == '0) || (tick && tog_cnt == NW'(1)));
    toggle  = (state_q == ST_RUN) && !abandon && tick && (tog_cnt > NW'(1));
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (any_req) state_d = ST_RUN;
      ST_RUN:  if (abandon || finish) state_d = (GAP == 0) ? ST_IDLE : ST_GAP;
      ST_GAP:  if (gap_cnt == '0) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register and per-run datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      tog_cnt <= '0;
      gap_cnt <= '0;
      grant   <= '0;
      done    <= '0;
      led     <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            grant          <= '0;
            grant[win_idx] <= 1'b1;
            own_q          <= win_idx;
            tog_cnt        <= win_nt;
            led            <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abandon || finish) begin
            grant   <= '0;
            led     <= 1'b0;
            tog_cnt <= '0;
            gap_cnt <= GW'((GAP > 0) ? GAP - 1 : 0);
            ptr_q   <= (own_q == PW'(NREQ - 1)) ? '0 : own_q + 1'b1;
            if (finish) done[own_q] <= 1'b1;
          end else if (toggle) begin
            led     <= ~led;
            tog_cnt <= tog_cnt - 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
